clk_div_multi: RTL

//  N-channel programmable clock divider for the Rx sampling path. Each channel derives a divided

---
 rtl/clk_div_pkg.sv | 13 +
 rtl/clk_div_multi_if.sv | 42 ++++
 rtl/clk_div_chan.sv | 76 +++++++
 rtl/clk_div_multi.sv | 40 ++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the multi-channel clock divider.
// Channel FSM encoding lives here so every unit agrees on it.
package clk_div_pkg;

  localparam int DIV_W_DEF       = 8;
  localparam int DEFAULT_DIV_DEF = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/clk_div_multi_if.sv
// Control/status bundle for clk_div_multi.
// sync exists only when CLKDIV_SYNC_EN is defined.
interface clk_div_multi_if #(
  parameter int N_CH  = 2,
  parameter int DIV_W = 8
);

  logic [N_CH-1:0]       en;
  logic [N_CH*DIV_W-1:0] div;
`ifdef CLKDIV_SYNC_EN
  logic                  sync;
`endif
  logic [N_CH-1:0]       pclk;
  logic [N_CH-1:0]       rise_stb;
  logic [N_CH-1:0]       fall_stb;
  logic [N_CH-1:0]       busy;

  modport master (
`ifdef CLKDIV_SYNC_EN
    output sync,
`endif
    output en,
    output div,
    input  pclk,
    input  rise_stb,
    input  fall_stb,
    input  busy
  );

  modport slave (
`ifdef CLKDIV_SYNC_EN
    input  sync,
`endif
    input  en,
    input  div,
    output pclk,
    output rise_stb,
    output fall_stb,
    output busy
  );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: run FSM, half-period counter, active divisor,
// registered divided clock with rise/fall strobes.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             aclk,
  input  logic             resetn,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             sync,
  output logic             pclk,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             busy
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

  state_e           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_act;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      div_act  <= DIV_RST;
      pclk     <= 1'b0;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          cnt  <= '0;
          pclk <= 1'b0;
          busy <= en;
          if (en) begin
            state   <= ST_RUN;
            div_act <= div;
          end
        end
        ST_RUN: begin
          // Priority: disable, then phase-align, then period boundary.
          if (!en) begin
            state <= ST_IDLE;
            cnt   <= '0;
            pclk  <= 1'b0;
            busy  <= 1'b0;
          end else if (sync) begin
            cnt     <= '0;
            pclk    <= 1'b0;
            div_act <= div;
          end else if (cnt == div_act) begin
            cnt      <= '0;
            pclk     <= ~pclk;
            rise_stb <= ~pclk;
            fall_stb <= pclk;
            // New divisor only at the 1->0 edge keeps periods whole.
            if (pclk) begin
              div_act <= div;
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// N-channel programmable clock divider with per-channel enables.
// Define CLKDIV_SYNC_EN to add the sync phase-align input.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input logic             aclk,
  input logic             resetn,
  clk_div_multi_if.slave  io
);

  logic sync_w;

`ifdef CLKDIV_SYNC_EN
  assign sync_w = io.sync;
`else
  assign sync_w = 1'b0;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    clk_div_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .aclk     (aclk),
      .resetn   (resetn),
      .en       (io.en[i]),
      .div      (io.div[i*DIV_W +: DIV_W]),
      .sync     (sync_w),
      .pclk     (io.pclk[i]),
      .rise_stb (io.rise_stb[i]),
      .fall_stb (io.fall_stb[i]),
      .busy     (io.busy[i])
    );
  end

endmodule
